control_mem: RTL
================

CONTROL_MEM -- requirements
Module: control_mem

Interface
REQ-001 SHALL have parameter: MAP_TOP, default 24'h000004, highest valid value of addr[31:8].
REQ-002 SHALL have parameter: ROM_PAGE, default 24'h000004, read-only page; stores to it fault.
REQ-003 clk  in  1  the one clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req_valid  in  1  access request from the EX/MEM stage.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-008 req_signed  in  1  sign-extend sub-word loads.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 req_rd  in  5  destination register tag.
REQ-012 stall  out  1  upstream holds all req_* stable while 1.
REQ-013 EscrMem  out  1  write strobe to data memory; memory writes on that clk edge.
REQ-014 LeerMem  out  1  read enable to data memory; Dataout is combinational, same cycle.
REQ-015 Direc  out  32  word address: {req_addr[31:2],2'b00}.
REQ-016 Datain  out  32  write word to memory.
REQ-017 Dataout  in  32  read word from memory.
REQ-018 wb_valid  out  1  registered load result valid.
REQ-019 wb_rd  out  5  registered tag.
REQ-020 wb_data  out  32  registered, extended load data.
REQ-021 fault  out  1  registered one-cycle pulse for a rejected access.

Function
REQ-022 Byte order is little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-023 Access is legal only if addr[31:8] <= MAP_TOP, is aligned for its size, and is not a store with addr[31:8] == ROM_PAGE.
REQ-024 FSM has exactly two states, IDLE and MERGE; reset state is IDLE.
REQ-025 IDLE, legal load: LeerMem=1, stall=0; next edge latches wb_data (lane selected, zero- or sign-extended), wb_rd and wb_valid=1.
REQ-026 IDLE, legal word store: EscrMem=1 and Datain=req_wdata the same cycle, stall=0; the access completes in 1 cycle.
REQ-027 IDLE, legal byte/half store: LeerMem=1, stall=1; next edge captures Dataout into the merge register and enters MERGE.
REQ-028 MERGE: EscrMem=1 and Datain=merge word with only the addressed lane(s) replaced by req_wdata[7:0]/[15:0]; stall=0; next edge returns to IDLE.
REQ-029 Illegal access: LeerMem=EscrMem=0, stall=0, next-cycle fault=1, wb_valid=0.
REQ-030 wb_valid and fault are 1-cycle pulses; wb_data and wb_rd hold their value until the next load.
REQ-031 With req_valid=0 in IDLE, LeerMem=EscrMem=stall=0, wb_valid=0 next cycle.
REQ-032 LeerMem and EscrMem are never both 1 in the same cycle.

Reset
REQ-033 With rst=1 at an edge: state=IDLE, wb_valid=0, wb_rd=0, wb_data=0, fault=0, merge register=0.
REQ-034 While rst=1, EscrMem=0, LeerMem=0 and stall=0 combinationally; reset in MERGE abandons the store with no memory write.

Configuration
REQ-035 Macro MISALIGN_TRAP_EN: when defined, a misaligned access is illegal per REQ-023 and pulses fault.
REQ-036 Without MISALIGN_TRAP_EN: alignment is not checked; half accesses force addr[0]=0, word accesses force addr[1:0]=0, and fault reports only range and ROM violations.

Verification
REQ-037 Store word 0xDEADBEEF at 0x010, then signed byte load at 0x013 -> EscrMem 1 cycle; next load gives wb_data=0xFFFFFFDE, wb_valid pulse.
REQ-038 Memory word 0x11223344 at 0x104, half store 0xABCD at 0x106 -> stall=1 for 1 cycle, LeerMem then EscrMem, Datain=0xABCD3344.
REQ-039 Store to 0x420 (ROM page) -> no EscrMem, fault=1 next cycle; unsigned byte load 0x420 proceeds normally.
REQ-040 Load at 0x500 -> LeerMem=0, fault=1, wb_valid=0.
REQ-041 rst asserted during MERGE of a byte store -> EscrMem never 1, state IDLE, all registered outputs 0.
REQ-042 Word load at 0x022: with MISALIGN_TRAP_EN -> fault=1; without -> Direc=0x020, wb_valid=1.

Source files
------------

// File: rtl/control_mem_if.sv
// Bus between the EX/MEM pipeline stage, the control_mem access unit and data memory.
// slave = the access unit, master = the pipeline/memory side driving it.
interface control_mem_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        stall;
  logic        EscrMem;
  logic        LeerMem;
  logic [31:0] Direc;
  logic [31:0] Datain;
  logic [31:0] Dataout;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;
  logic        dbg_state;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd, Dataout,
    output stall, EscrMem, LeerMem, Direc, Datain, wb_valid, wb_rd, wb_data, fault, dbg_state
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd, Dataout,
    input  stall, EscrMem, LeerMem, Direc, Datain, wb_valid, wb_rd, wb_data, fault, dbg_state
  );
endinterface

// File: rtl/control_mem.sv
// Load/store unit between the pipeline and a word-wide data memory; sub-word stores use read-modify-write.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses fault instead of being silently aligned.
module control_mem #(
  parameter logic [23:0] MAP_TOP  = 24'h000004,
  parameter logic [23:0] ROM_PAGE = 24'h000004
) (
  input  logic         clk,
  input  logic         rst,
  control_mem_if.slave bus
);
  // Handshake: while stall=1 the requester keeps every req_* stable; a request is
  // consumed on the rising edge where req_valid=1 and stall=0.
  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        fault_q, fault_d;

  logic [23:0] page;
  logic        is_byte, is_half, is_word;
  logic        aligned, legal, active;
  logic [1:0]  lane;
  logic [31:0] rd_shift, load_data, merged;
  logic        leer, escr, stall;
  logic [31:0] datain;

  always_comb begin
    page    = bus.req_addr[31:8];
    is_byte = (bus.req_size == 2'b00);
    is_half = (bus.req_size == 2'b01);
    is_word = bus.req_size[1];
    lane    = is_word ? 2'b00 : (is_half ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0]);
`ifdef MISALIGN_TRAP_EN
    aligned = is_byte || (is_half && !bus.req_addr[0]) || (is_word && (bus.req_addr[1:0] == 2'b00));
`else
    aligned = 1'b1;
`endif
    legal  = (page <= MAP_TOP) && aligned && !(bus.req_we && (page == ROM_PAGE));
    active = !rst && bus.req_valid;

    rd_shift = bus.Dataout >> {lane, 3'b000};
    if (is_byte)
      load_data = {{24{bus.req_signed & rd_shift[7]}}, rd_shift[7:0]};
    else if (is_half)
      load_data = {{16{bus.req_signed & rd_shift[15]}}, rd_shift[15:0]};
    else
      load_data = bus.Dataout;

    // Only the addressed lane(s) of the captured word are replaced.
    merged = merge_q;
    if (is_byte)
      merged[{lane, 3'b000} +: 8] = bus.req_wdata[7:0];
    else
      merged[{lane[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
  end

  always_comb begin
    leer       = 1'b0;
    escr       = 1'b0;
    stall      = 1'b0;
    datain     = bus.req_wdata;
    state_d    = state_q;
    merge_d    = merge_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    fault_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (active) begin
          if (!legal) begin
            fault_d = 1'b1;
          end else if (!bus.req_we) begin
            leer       = 1'b1;
            wb_valid_d = 1'b1;
            wb_rd_d    = bus.req_rd;
            wb_data_d  = load_data;
          end else if (is_word) begin
            escr = 1'b1;
          end else begin
            leer    = 1'b1;
            stall   = 1'b1;
            merge_d = bus.Dataout;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        escr    = !rst;
        datain  = merged;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      merge_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      merge_q    <= merge_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.LeerMem   = leer;
  assign bus.EscrMem   = escr;
  assign bus.stall     = stall;
  assign bus.Datain    = datain;
  assign bus.Direc     = {bus.req_addr[31:2], 2'b00};
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.fault     = fault_q;
  assign bus.dbg_state = state_q;
endmodule
